// File: rtl/loadable_instruction_memory_if.sv
// Load and fetch port bundle for loadable_instruction_memory.
// The memory takes the slave modport; the core or loader takes the master modport.
interface loadable_instruction_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    // Load handshake: a word moves on every cycle where loadValid && loadReady are both high.
    // The memory raises loadReady throughout a load and ignores loadValid at all other times.
    logic                  loadStart;
    logic [ADDR_WIDTH:0]   loadLength;
    logic                  loadValid;
    logic [DATA_WIDTH-1:0] loadWord;
    logic                  loadReady;
    logic                  loadDone;
    logic                  programReady;
    logic                  fetchEnable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] instructionOut;
    logic                  instructionValid;
    logic                  parityError;

    modport master (
        output loadStart, loadLength, loadValid, loadWord, fetchEnable, address,
        input  loadReady, loadDone, programReady, instructionOut, instructionValid, parityError
    );

    modport slave (
        input  loadStart, loadLength, loadValid, loadWord, fetchEnable, address,
        output loadReady, loadDone, programReady, instructionOut, instructionValid, parityError
    );
endinterface

// File: rtl/loadable_instruction_memory.sv
// Run-time loadable instruction memory with a registered, 1-cycle fetch port.
// Optional feature: define LOADABLE_IMEM_PARITY_EN to store and check one even-parity bit per word.
module loadable_instruction_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h6C000000
) (
    input  logic                          clock,
    input  logic                          reset,
    loadable_instruction_memory_if.slave  bus,
    output logic [1:0]                    dbg_state
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
`ifdef LOADABLE_IMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      write_ptr_q, write_ptr_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      loaded_len_q, loaded_len_d;
    logic                  program_ready_q, program_ready_d;
    logic                  load_done_q, load_done_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  parity_err_q, parity_err_d;

    logic [MEM_W-1:0]      mem_q [DEPTH];
    logic                  mem_we;
    logic [MEM_W-1:0]      mem_wdata;
    logic [MEM_W-1:0]      rd_word;
    logic [LEN_W-1:0]      req_len;
    logic                  rd_parity_bad;

    assign req_len = (bus.loadLength > DEPTH_L) ? DEPTH_L : bus.loadLength;
    assign rd_word = mem_q[bus.address];

`ifdef LOADABLE_IMEM_PARITY_EN
    assign mem_wdata     = {^bus.loadWord, bus.loadWord};
    assign rd_parity_bad = ^rd_word;
`else
    assign mem_wdata     = bus.loadWord;
    assign rd_parity_bad = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        write_ptr_d     = write_ptr_q;
        len_d           = len_q;
        loaded_len_d    = loaded_len_q;
        program_ready_d = program_ready_q;
        load_done_d     = 1'b0;
        mem_we          = 1'b0;
        unique case (state_q)
            IDLE, READY: begin
                if (bus.loadStart) begin
                    write_ptr_d     = '0;
                    len_d           = req_len;
                    program_ready_d = 1'b0;
                    if (req_len == '0) begin
                        // An empty program is complete at once; every fetch then misses.
                        state_d         = READY;
                        loaded_len_d    = '0;
                        program_ready_d = 1'b1;
                        load_done_d     = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.loadValid) begin
                    mem_we      = 1'b1;
                    write_ptr_d = write_ptr_q + 1'b1;
                    if (write_ptr_q == len_q - 1'b1) begin
                        state_d         = READY;
                        loaded_len_d    = len_q;
                        program_ready_d = 1'b1;
                        load_done_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        parity_err_d  = 1'b0;
        if (bus.fetchEnable) begin
            if (program_ready_q && ({1'b0, bus.address} < loaded_len_q)) begin
                instr_valid_d = 1'b1;
                parity_err_d  = rd_parity_bad;
                instr_d       = rd_parity_bad ? NOP_WORD : rd_word[DATA_WIDTH-1:0];
            end else begin
                instr_d = NOP_WORD;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            write_ptr_q     <= '0;
            len_q           <= '0;
            loaded_len_q    <= '0;
            program_ready_q <= 1'b0;
            load_done_q     <= 1'b0;
            instr_q         <= NOP_WORD;
            instr_valid_q   <= 1'b0;
            parity_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_ptr_q     <= write_ptr_d;
            len_q           <= len_d;
            loaded_len_q    <= loaded_len_d;
            program_ready_q <= program_ready_d;
            load_done_q     <= load_done_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            parity_err_q    <= parity_err_d;
        end
    end

    // Array contents deliberately survive reset; only loaded_len gates their use.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[write_ptr_q[ADDR_WIDTH-1:0]] <= mem_wdata;
        end
    end

    assign bus.loadReady        = (state_q == LOAD);
    assign bus.loadDone         = load_done_q;
    assign bus.programReady     = program_ready_q;
    assign bus.instructionOut   = instr_q;
    assign bus.instructionValid = instr_valid_q;
    assign bus.parityError      = parity_err_q;
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_loadable_instruction_memory.sv
// Directed bench for loadable_instruction_memory: reset, a gapped load, fetch boundaries,
// an oversize load, an aborted load and (with LOADABLE_IMEM_PARITY_EN) a corrupted word.
module tb_loadable_instruction_memory;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam logic [DW-1:0] NOP = 32'h6C000000;
    localparam logic [DW-1:0] WA = 32'h1111_0001;
    localparam logic [DW-1:0] WB = 32'h2222_0002;
    localparam logic [DW-1:0] WC = 32'h3333_0003;
    localparam logic [DW-1:0] BASE = 32'hA000_0000;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_cmp;
    int         n_bad;
    int         n_acc;
    int         n_done;

    loadable_instruction_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    loadable_instruction_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave),
        .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        bus.fetchEnable = 1'b1;
        bus.address     = a;
        step();
        bus.fetchEnable = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        bus.loadValid = 1'b1;
        bus.loadWord  = w;
        step();
        bus.loadValid = 1'b0;
    endtask

    task automatic start_load(input logic [AW:0] len);
        bus.loadStart  = 1'b1;
        bus.loadLength = len;
        step();
        bus.loadStart  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.loadStart   = 1'b0;
        bus.loadLength  = '0;
        bus.loadValid   = 1'b0;
        bus.loadWord    = '0;
        bus.fetchEnable = 1'b0;
        bus.address     = '0;
        reset = 1'b0;
        step();
        step();
        check("rst_load_ready", 64'(bus.loadReady), 64'd0);
        check("rst_load_done", 64'(bus.loadDone), 64'd0);
        check("rst_prog_ready", 64'(bus.programReady), 64'd0);
        check("rst_instr_valid", 64'(bus.instructionValid), 64'd0);
        check("rst_instr_out", 64'(bus.instructionOut), 64'(NOP));
        check("rst_parity", 64'(bus.parityError), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b1;
        step();

        // No program yet: fetch returns NOP.
        fetch(10'd0);
        check("noload_instr", 64'(bus.instructionOut), 64'(NOP));
        check("noload_valid", 64'(bus.instructionValid), 64'd0);
        check("noload_prog_ready", 64'(bus.programReady), 64'd0);

        // Three-word load with a gap after B.
        start_load(11'd3);
        check("ld3_ready_0", 64'(bus.loadReady), 64'd1);
        check("ld3_state", 64'(dbg_state), 64'd1);
        push(WA);
        check("ld3_ready_1", 64'(bus.loadReady), 64'd1);
        check("ld3_done_early", 64'(bus.loadDone), 64'd0);
        push(WB);
        step();
        check("ld3_ready_gap", 64'(bus.loadReady), 64'd1);
        check("ld3_prog_during", 64'(bus.programReady), 64'd0);
        push(WC);
        check("ld3_done_pulse", 64'(bus.loadDone), 64'd1);
        check("ld3_prog_ready", 64'(bus.programReady), 64'd1);
        check("ld3_ready_after", 64'(bus.loadReady), 64'd0);
        step();
        check("ld3_done_cleared", 64'(bus.loadDone), 64'd0);

        // Back-to-back fetch 0..3.
        bus.fetchEnable = 1'b1;
        bus.address = 10'd0; step();
        check("f0_instr", 64'(bus.instructionOut), 64'(WA));
        check("f0_valid", 64'(bus.instructionValid), 64'd1);
        bus.address = 10'd1; step();
        check("f1_instr", 64'(bus.instructionOut), 64'(WB));
        check("f1_valid", 64'(bus.instructionValid), 64'd1);
        bus.address = 10'd2; step();
        check("f2_instr", 64'(bus.instructionOut), 64'(WC));
        check("f2_valid", 64'(bus.instructionValid), 64'd1);
        bus.address = 10'd3; step();
        check("f3_instr", 64'(bus.instructionOut), 64'(NOP));
        check("f3_valid", 64'(bus.instructionValid), 64'd0);
        bus.fetchEnable = 1'b0;

        // Output holds when fetch is idle.
        fetch(10'd1);
        step();
        check("hold_instr", 64'(bus.instructionOut), 64'(WB));
        check("hold_valid", 64'(bus.instructionValid), 64'd0);

        // Oversize load: only DEPTH words are accepted.
        start_load(11'(DEPTH + 5));
        check("big_prog_cleared", 64'(bus.programReady), 64'd0);
        n_acc = 0;
        n_done = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            bus.loadValid = 1'b1;
            bus.loadWord  = BASE + DW'(n_acc);
            if (bus.loadReady) n_acc++;
            step();
            if (bus.loadDone) n_done++;
        end
        bus.loadValid = 1'b0;
        check("big_accepted", 64'(n_acc), 64'(DEPTH));
        check("big_done_count", 64'(n_done), 64'd1);
        check("big_prog_ready", 64'(bus.programReady), 64'd1);
        fetch(10'(DEPTH - 1));
        check("big_last_instr", 64'(bus.instructionOut), 64'(BASE + DW'(DEPTH - 1)));
        check("big_last_valid", 64'(bus.instructionValid), 64'd1);
        fetch(10'd0);
        check("big_first_instr", 64'(bus.instructionOut), 64'(BASE));

`ifdef LOADABLE_IMEM_PARITY_EN
        dut.mem_q[7] = dut.mem_q[7] ^ 33'd1;
        fetch(10'd7);
        check("par_error", 64'(bus.parityError), 64'd1);
        check("par_instr", 64'(bus.instructionOut), 64'(NOP));
        check("par_valid", 64'(bus.instructionValid), 64'd1);
        fetch(10'd8);
        check("par_clean", 64'(bus.parityError), 64'd0);
`endif

        // Reset in the middle of a 4-word load.
        start_load(11'd4);
        push(32'hDEAD_0000);
        push(32'hDEAD_0001);
        #2 reset = 1'b0;
        #1;
        check("abort_prog_ready", 64'(bus.programReady), 64'd0);
        check("abort_load_ready", 64'(bus.loadReady), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("abort_state", 64'(dbg_state), 64'd0);
        fetch(10'd0);
        check("abort_instr", 64'(bus.instructionOut), 64'(NOP));
        check("abort_valid", 64'(bus.instructionValid), 64'd0);

        // Short reload: address at loadedLen must miss.
        start_load(11'd2);
        push(WC);
        push(WA);
        fetch(10'd1);
        check("short_instr1", 64'(bus.instructionOut), 64'(WA));
        fetch(10'd2);
        check("short_edge_instr", 64'(bus.instructionOut), 64'(NOP));
        check("short_edge_valid", 64'(bus.instructionValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
